// File: rtl/nes_clk_pkg.sv
// Shared definitions for the NES clock-enable generator: FSM encoding and
// the nominal NES divider constants.
package nes_clk_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2
  } nes_clk_state_e;

  localparam int NES_CPU_DIV   = 12;
  localparam int NES_PPU_DIV   = 4;
  localparam int NES_MASTER_HZ = 21477272;

  // Counter width for a modulo-div counter, never narrower than one bit.
  function automatic int phase_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser with a synchronous clear that empties
// both stages, so a cleared synchroniser reports 0 for two cycles.
module sync_2ff (
  input  logic clk_i,
  input  logic clr_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/nes_clock_gen.sv
// Holds the NES core in reset until PLL lock has been stable, then emits
// phase-locked CPU and PPU clock enables on the master clock.
module nes_clock_gen
  import nes_clk_pkg::*;
#(
  parameter int CPU_DIV     = NES_CPU_DIV,
  parameter int PPU_DIV     = NES_PPU_DIV,
  parameter int HOLD_CYCLES = 1024,
  localparam int PW  = phase_width(CPU_DIV),
  localparam int DW  = phase_width(PPU_DIV),
  localparam int HW  = $clog2(HOLD_CYCLES + 1)
) (
  input  logic           clk_i,
  input  logic           reset_i,
  input  logic           pll_locked_i,
  output logic           sys_reset_o,
  output logic           cpu_ce_o,
  output logic           ppu_ce_o,
  output logic [PW-1:0]  cpu_phase_o,
  output nes_clk_state_e dbg_state_o
);

  if ((PPU_DIV < 1) || (CPU_DIV < PPU_DIV) || ((CPU_DIV % PPU_DIV) != 0)) begin : g_bad_div
    $error("nes_clock_gen: CPU_DIV must be a positive multiple of PPU_DIV");
  end

  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("nes_clock_gen: HOLD_CYCLES must be at least 1");
  end

  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
  localparam logic [PW-1:0] PHASE_LAST = PW'(CPU_DIV - 1);
  localparam logic [DW-1:0] DOT_LAST   = DW'(PPU_DIV - 1);

  logic lock_s;

  sync_2ff u_lock_sync (
    .clk_i (clk_i),
    .clr_i (reset_i),
    .d_i   (pll_locked_i),
    .q_o   (lock_s)
  );

  nes_clk_state_e state_q, state_d;
  logic [HW-1:0]  hold_cnt_q, hold_cnt_d;
  logic [PW-1:0]  phase_q, phase_d;
  logic [DW-1:0]  dot_q, dot_d;
  logic           sys_reset_q;
  logic           cpu_ce_q;
  logic           ppu_ce_q;
  logic           run_d;
  logic           stay_run;

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    unique case (state_q)
      WAIT_LOCK: begin
        hold_cnt_d = '0;
        if (lock_s) state_d = HOLD;
      end
      HOLD: begin
        if (!lock_s) begin
          state_d    = WAIT_LOCK;
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d = RUN;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      RUN: begin
        // hold_cnt stays saturated at HOLD_LAST while running.
        if (!lock_s) begin
          state_d    = WAIT_LOCK;
          hold_cnt_d = '0;
        end
      end
      default: begin
        state_d    = WAIT_LOCK;
        hold_cnt_d = '0;
      end
    endcase
  end

  // The dot counter runs in lock step with the phase counter; because CPU_DIV
  // is a multiple of PPU_DIV both wrap to 0 on the same cycle.
  always_comb begin
    run_d    = (state_d == RUN);
    stay_run = run_d && (state_q == RUN);
    phase_d  = '0;
    dot_d    = '0;
    if (stay_run) begin
      phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + 1'b1;
      dot_d   = (dot_q == DOT_LAST) ? '0 : dot_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= WAIT_LOCK;
      hold_cnt_q  <= '0;
      phase_q     <= '0;
      dot_q       <= '0;
      sys_reset_q <= 1'b1;
      cpu_ce_q    <= 1'b0;
      ppu_ce_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      phase_q     <= phase_d;
      dot_q       <= dot_d;
      sys_reset_q <= !run_d;
      cpu_ce_q    <= run_d && (phase_d == '0);
      ppu_ce_q    <= run_d && (dot_d == '0);
    end
  end

  assign sys_reset_o = sys_reset_q;
  assign cpu_ce_o    = cpu_ce_q;
  assign ppu_ce_o    = ppu_ce_q;
  assign cpu_phase_o = phase_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_nes_clock_gen.sv
// Self-checking bench for nes_clock_gen with HOLD_CYCLES=8: a default 12/4
// instance and a 6/2 instance share the same clock, reset and lock stimulus.
module tb_nes_clock_gen;
  import nes_clk_pkg::*;

  localparam int HOLD  = 8;
  localparam int CDIV  = 12;
  localparam int PDIV  = 4;
  localparam int CDIV6 = 6;
  localparam int PDIV6 = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pll_locked = 1'b0;

  logic           sys_reset, cpu_ce, ppu_ce;
  logic [3:0]     cpu_phase;
  nes_clk_state_e dbg_state;
  logic           sys_reset6, cpu_ce6, ppu_ce6;
  logic [2:0]     cpu_phase6;
  nes_clk_state_e dbg_state6;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  nes_clock_gen #(.CPU_DIV(CDIV), .PPU_DIV(PDIV), .HOLD_CYCLES(HOLD)) u_dut (
    .clk_i(clk), .reset_i(reset), .pll_locked_i(pll_locked),
    .sys_reset_o(sys_reset), .cpu_ce_o(cpu_ce), .ppu_ce_o(ppu_ce),
    .cpu_phase_o(cpu_phase), .dbg_state_o(dbg_state)
  );

  nes_clock_gen #(.CPU_DIV(CDIV6), .PPU_DIV(PDIV6), .HOLD_CYCLES(HOLD)) u_dut6 (
    .clk_i(clk), .reset_i(reset), .pll_locked_i(pll_locked),
    .sys_reset_o(sys_reset6), .cpu_ce_o(cpu_ce6), .ppu_ce_o(ppu_ce6),
    .cpu_phase_o(cpu_phase6), .dbg_state_o(dbg_state6)
  );

  // Reference model: the core may run once the synchronised lock has been
  // seen high on HOLD+1 consecutive edges; the phase is the number of
  // running cycles so far, modulo the CPU divider.
  int edge_no = 0;
  int streak  = 0;
  int run_cnt = 0;
  bit p1 = 0, p2 = 0, r1 = 1, r2 = 1;
  bit exp_sys_reset = 1, exp_cpu_ce = 0, exp_ppu_ce = 0;
  bit exp_cpu_ce6 = 0, exp_ppu_ce6 = 0;
  int exp_phase = 0, exp_phase6 = 0, exp_state = 0;

  always @(posedge clk) begin
    bit seen;
    bit run;
    edge_no++;
    seen = !r1 && !r2 && p2;
    if (reset) begin
      streak  = 0;
      run_cnt = 0;
    end else begin
      streak  = seen ? streak + 1 : 0;
      run     = (streak >= HOLD + 1);
      run_cnt = run ? run_cnt + 1 : 0;
    end
    run           = (run_cnt > 0);
    exp_sys_reset = !run;
    exp_phase     = run ? (run_cnt - 1) % CDIV : 0;
    exp_cpu_ce    = run && (exp_phase == 0);
    exp_ppu_ce    = run && (exp_phase % PDIV == 0);
    exp_phase6    = run ? (run_cnt - 1) % CDIV6 : 0;
    exp_cpu_ce6   = run && (exp_phase6 == 0);
    exp_ppu_ce6   = run && (exp_phase6 % PDIV6 == 0);
    exp_state     = run ? 2 : (streak > 0 ? 1 : 0);
    p2 = p1; p1 = pll_locked;
    r2 = r1; r1 = reset;
  end

  function automatic logic [8:0] obs_main();
    return {dbg_state, sys_reset, cpu_ce, ppu_ce, cpu_phase};
  endfunction

  function automatic logic [8:0] exp_main();
    return {2'(exp_state), exp_sys_reset, exp_cpu_ce, exp_ppu_ce, 4'(exp_phase)};
  endfunction

  function automatic logic [5:0] obs_six();
    return {sys_reset6, cpu_ce6, ppu_ce6, cpu_phase6};
  endfunction

  function automatic logic [5:0] exp_six();
    return {exp_sys_reset, exp_cpu_ce6, exp_ppu_ce6, 3'(exp_phase6)};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    pll_locked = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({sys_reset, cpu_ce, ppu_ce, cpu_phase} !== 7'b1_0_0_0000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 1000000", {sys_reset, cpu_ce, ppu_ce, cpu_phase});
    end
    n_tests++;
    if (dbg_state !== WAIT_LOCK) begin
      n_fail++;
      $display("FAIL reset_state: got %0d expected %0d", dbg_state, WAIT_LOCK);
    end
    reset = 1'b0;
  endtask

  task automatic test_power_up();
    repeat (20) begin
      @(negedge clk);
      n_tests++;
      if (obs_main() !== exp_main() || sys_reset !== 1'b1) begin
        n_fail++;
        $display("FAIL power_up @%0d: got %b expected %b", edge_no, obs_main(), exp_main());
      end
    end
  endtask

  task automatic test_lock_acquire();
    int t0;
    int n_cpu;
    int n_ppu;
    int n_orphan;
    bit released;
    pll_locked = 1'b1;
    t0 = edge_no + 1;
    released = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n_tests++;
      if (obs_main() !== exp_main()) begin
        n_fail++;
        $display("FAIL acquire @%0d: got %b expected %b", edge_no, obs_main(), exp_main());
      end
      if (sys_reset === 1'b0) begin
        released = 1;
        break;
      end
    end
    n_tests++;
    if (!released || (edge_no - t0) != 2 + HOLD) begin
      n_fail++;
      $display("FAIL acquire_latency: got %0d edges (released=%0d) expected %0d", edge_no - t0, released, 2 + HOLD);
    end
    n_tests++;
    if ({cpu_ce, ppu_ce, cpu_phase} !== 6'b1_1_0000) begin
      n_fail++;
      $display("FAIL acquire_first_run: got %b expected 110000", {cpu_ce, ppu_ce, cpu_phase});
    end
    n_cpu = 0; n_ppu = 0; n_orphan = 0;
    for (int i = 0; i < 120; i++) begin
      if (i > 0) @(negedge clk);
      n_tests++;
      if (obs_main() !== exp_main()) begin
        n_fail++;
        $display("FAIL acquire_run @%0d: got %b expected %b", edge_no, obs_main(), exp_main());
      end
      n_cpu += int'(cpu_ce);
      n_ppu += int'(ppu_ce);
      if (cpu_ce && !ppu_ce) n_orphan++;
    end
    n_tests++;
    if (n_cpu != 10 || n_ppu != 30) begin
      n_fail++;
      $display("FAIL acquire_counts: got cpu=%0d ppu=%0d expected cpu=10 ppu=30", n_cpu, n_ppu);
    end
    n_tests++;
    if (n_orphan != 0) begin
      n_fail++;
      $display("FAIL acquire_alignment: got %0d cpu_ce without ppu_ce expected 0", n_orphan);
    end
  endtask

  task automatic test_glitch();
    int t_rise;
    bit released;
    pll_locked = 1'b0;
    repeat (6) begin
      @(negedge clk);
      n_tests++;
      if (obs_main() !== exp_main()) begin
        n_fail++;
        $display("FAIL glitch_drop @%0d: got %b expected %b", edge_no, obs_main(), exp_main());
      end
    end
    for (int i = 0; i < 10; i++) begin
      pll_locked = !(i >= 5 && i < 8);
      if (i == 8) t_rise = edge_no + 1;
      @(negedge clk);
      n_tests++;
      if (obs_main() !== exp_main() || sys_reset !== 1'b1) begin
        n_fail++;
        $display("FAIL glitch_hold @%0d: got %b expected %b", edge_no, obs_main(), exp_main());
      end
    end
    released = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      n_tests++;
      if (obs_main() !== exp_main()) begin
        n_fail++;
        $display("FAIL glitch_release @%0d: got %b expected %b", edge_no, obs_main(), exp_main());
      end
      if (sys_reset === 1'b0) begin
        released = 1;
        break;
      end
    end
    n_tests++;
    if (!released || (edge_no - t_rise) != 2 + HOLD) begin
      n_fail++;
      $display("FAIL glitch_latency: got %0d edges (released=%0d) expected %0d", edge_no - t_rise, released, 2 + HOLD);
    end
  endtask

  task automatic test_lock_loss();
    bit found;
    int e0;
    found = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n_tests++;
      if (obs_main() !== exp_main()) begin
        n_fail++;
        $display("FAIL loss_wait @%0d: got %b expected %b", edge_no, obs_main(), exp_main());
      end
      if (cpu_phase === 4'd7 && sys_reset === 1'b0) begin
        found = 1;
        break;
      end
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL loss_phase7: got no phase 7 in 40 cycles expected phase 7");
    end
    pll_locked = 1'b0;
    e0 = edge_no;
    found = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_tests++;
      if (obs_main() !== exp_main()) begin
        n_fail++;
        $display("FAIL loss_drop @%0d: got %b expected %b", edge_no, obs_main(), exp_main());
      end
      if (sys_reset === 1'b1) begin
        found = 1;
        break;
      end
    end
    n_tests++;
    if (!found || (edge_no - e0) > 3) begin
      n_fail++;
      $display("FAIL loss_latency: got %0d edges (seen=%0d) expected <=3", edge_no - e0, found);
    end
    repeat (8) begin
      @(negedge clk);
      n_tests++;
      if (cpu_ce !== 1'b0 || ppu_ce !== 1'b0 || obs_main() !== exp_main()) begin
        n_fail++;
        $display("FAIL loss_quiet @%0d: got %b expected %b", edge_no, obs_main(), exp_main());
      end
    end
    pll_locked = 1'b1;
    found = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      n_tests++;
      if (obs_main() !== exp_main()) begin
        n_fail++;
        $display("FAIL relock @%0d: got %b expected %b", edge_no, obs_main(), exp_main());
      end
      if (sys_reset === 1'b0) begin
        found = 1;
        break;
      end
    end
    n_tests++;
    if (!found || {cpu_ce, ppu_ce, cpu_phase} !== 6'b1_1_0000) begin
      n_fail++;
      $display("FAIL relock_first_run: got %b (released=%0d) expected 110000", {cpu_ce, ppu_ce, cpu_phase}, found);
    end
  endtask

  task automatic test_reset_pulse();
    int r_edge;
    int n_ce;
    bit released;
    repeat ($urandom_range(1, 11)) @(negedge clk);
    reset = 1'b1;
    r_edge = edge_no + 1;
    @(negedge clk);
    reset = 1'b0;
    n_tests++;
    if ({sys_reset, cpu_ce, ppu_ce, cpu_phase} !== 7'b1_0_0_0000 || dbg_state !== WAIT_LOCK) begin
      n_fail++;
      $display("FAIL pulse_reset: got %b/%0d expected 1000000/0", {sys_reset, cpu_ce, ppu_ce, cpu_phase}, dbg_state);
    end
    n_ce = 0;
    released = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      n_tests++;
      if (obs_main() !== exp_main()) begin
        n_fail++;
        $display("FAIL pulse_hold @%0d: got %b expected %b", edge_no, obs_main(), exp_main());
      end
      if (sys_reset === 1'b0) begin
        released = 1;
        break;
      end
      if (cpu_ce || ppu_ce) n_ce++;
    end
    n_tests++;
    if (!released || n_ce != 0 || (edge_no - (r_edge + 1)) != 2 + HOLD) begin
      n_fail++;
      $display("FAIL pulse_latency: got %0d edges after release, %0d ces expected %0d edges, 0 ces",
               edge_no - (r_edge + 1), n_ce, 2 + HOLD);
    end
  endtask

  task automatic test_small_div();
    int n_cpu;
    int n_ppu;
    int n_bad;
    n_cpu = 0; n_ppu = 0; n_bad = 0;
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      n_tests++;
      if (obs_six() !== exp_six()) begin
        n_fail++;
        $display("FAIL div6 @%0d: got %b expected %b", edge_no, obs_six(), exp_six());
      end
      n_cpu += int'(cpu_ce6);
      n_ppu += int'(ppu_ce6);
      if (ppu_ce6 && cpu_phase6[0]) n_bad++;
      if (cpu_ce6 && cpu_phase6 != 3'd0) n_bad++;
    end
    n_tests++;
    if (n_cpu != 6 || n_ppu != 18 || n_bad != 0) begin
      n_fail++;
      $display("FAIL div6_counts: got cpu=%0d ppu=%0d misplaced=%0d expected cpu=6 ppu=18 misplaced=0",
               n_cpu, n_ppu, n_bad);
    end
  endtask

  task automatic test_random();
    int seg;
    for (int i = 0; i < 600; i++) begin
      if (seg <= 0) begin
        seg = $urandom_range(1, 30);
        pll_locked = ($urandom_range(0, 9) < 7);
      end
      seg--;
      reset = ($urandom_range(0, 59) == 0);
      @(negedge clk);
      n_tests++;
      if (obs_main() !== exp_main() || obs_six() !== exp_six()) begin
        n_fail++;
        $display("FAIL random @%0d: got %b/%b expected %b/%b", edge_no, obs_main(), obs_six(), exp_main(), exp_six());
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_lock_acquire();
    test_glitch();
    test_lock_loss();
    test_small_div();
    test_reset_pulse();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
